// File: rtl/mem_stage.sv
// Memory stage of the five-stage MIPS pipeline: load/store decode, byte-enabled data
// memory, address-exception detection and the M->W pipeline register.
module mem_stage #(
  parameter int DM_WORDS = 3072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] M_instruc,
  input  logic [31:0] M_PC,
  input  logic [31:0] M_AluRe,
  input  logic [31:0] M_WD,
  input  logic [4:0]  M_WRA,
  input  logic        IntReq,
  output logic        M_Exc,
  output logic [4:0]  M_ExcCode,
  output logic [3:0]  M_DMByteEn,
  output logic [31:0] W_instruc,
  output logic [31:0] W_PC,
  output logic [31:0] W_DM,
  output logic [31:0] W_AluRe,
  output logic [4:0]  W_WRA
);

  localparam int          AW       = $clog2(DM_WORDS);
  localparam logic [31:0] DM_BYTES = 32'(4 * DM_WORDS);

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  logic [31:0] mem [DM_WORDS];

  logic          is_load, is_store;
  logic          acc_word, acc_half, acc_byte;
  logic [AW-1:0] idx;
  logic [31:0]   wdata;
  logic [31:0]   rd_word;
  logic [15:0]   rd_half;
  logic [7:0]    rd_byte;
  logic [31:0]   load_data;

  assign idx = M_AluRe[AW+1:2];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    acc_word = 1'b0;
    acc_half = 1'b0;
    acc_byte = 1'b0;
    case (M_instruc[31:26])
      OP_LW:         begin is_load  = 1'b1; acc_word = 1'b1; end
      OP_LH, OP_LHU: begin is_load  = 1'b1; acc_half = 1'b1; end
      OP_LB, OP_LBU: begin is_load  = 1'b1; acc_byte = 1'b1; end
      OP_SW:         begin is_store = 1'b1; acc_word = 1'b1; end
      OP_SH:         begin is_store = 1'b1; acc_half = 1'b1; end
      OP_SB:         begin is_store = 1'b1; acc_byte = 1'b1; end
      default:       ;
    endcase
  end

  // Byte accesses can only fault by falling outside the memory.
  always_comb begin
    M_Exc     = 1'b0;
    M_ExcCode = 5'd0;
    if (is_load || is_store) begin
      M_Exc = (M_AluRe >= DM_BYTES) ||
              (acc_word && (M_AluRe[1:0] != 2'b00)) ||
              (acc_half && M_AluRe[0]);
      if (M_Exc) M_ExcCode = is_load ? 5'd4 : 5'd5;
    end
  end

  always_comb begin
    M_DMByteEn = 4'b0000;
    wdata      = M_WD;
    if (acc_half) wdata = {2{M_WD[15:0]}};
    if (acc_byte) wdata = {4{M_WD[7:0]}};
    if (is_store && !M_Exc && !IntReq && !reset) begin
      if (acc_word)      M_DMByteEn = 4'b1111;
      else if (acc_half) M_DMByteEn = 4'b0011 << M_AluRe[1:0];
      else               M_DMByteEn = 4'b0001 << M_AluRe[1:0];
    end
  end

  // Loads are right-justified only; sign extension happens in write-back.
  always_comb begin
    rd_word = mem[idx];
    rd_half = M_AluRe[1] ? rd_word[31:16] : rd_word[15:0];
    case (M_AluRe[1:0])
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    load_data = 32'd0;
    if (is_load) begin
      if (acc_word)      load_data = rd_word;
      else if (acc_half) load_data = {16'd0, rd_half};
      else               load_data = {24'd0, rd_byte};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      W_instruc <= 32'd0;
      W_PC      <= 32'd0;
      W_DM      <= 32'd0;
      W_AluRe   <= 32'd0;
      W_WRA     <= 5'd0;
      for (int i = 0; i < DM_WORDS; i++) mem[i] <= 32'd0;
    end else begin
      // Byte enables are already masked by IntReq and exceptions.
      for (int b = 0; b < 4; b++)
        if (M_DMByteEn[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      if (IntReq) begin
        W_instruc <= 32'd0;
        W_PC      <= 32'd0;
        W_DM      <= 32'd0;
        W_AluRe   <= 32'd0;
        W_WRA     <= 5'd0;
      end else if (M_Exc) begin
        W_instruc <= 32'd0;
        W_PC      <= M_PC;
        W_DM      <= 32'd0;
        W_AluRe   <= M_AluRe;
        W_WRA     <= 5'd0;
      end else begin
        W_instruc <= M_instruc;
        W_PC      <= M_PC;
        W_DM      <= load_data;
        W_AluRe   <= M_AluRe;
        W_WRA     <= M_WRA;
      end
    end
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the P7 five-stage MIPS pipeline, directly upstream of the write-back stage. Decodes load/store opcodes of the M-stage instruction, performs byte-enabled accesses to a word-organised data memory, detects address exceptions, and registers the M→W pipeline state (instruction, PC, ALU result, destination register, right-justified load data). Write-back then sign- or zero-extends and selects the register write data.

## Interface
Parameters:
- DM_WORDS, 3072: data memory depth in 32-bit words (byte range 0x0000–0x2FFF).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high.
- M_instruc  input  32  instruction in M.
- M_PC  input  32  PC of that instruction.
- M_AluRe  input  32  ALU result; byte address for loads/stores.
- M_WD  input  32  store data (forwarded rt value).
- M_WRA  input  5  destination register number.
- IntReq  input  1  interrupt/exception accepted by CP0; flush.
- M_Exc  output  1  combinational: address exception in M.
- M_ExcCode  output  5  combinational: 4 = AdEL, 5 = AdES, 0 otherwise.
- M_DMByteEn  output  4  combinational: byte lanes written this cycle (debug/bench).
- W_instruc, W_PC, W_DM, W_AluRe  output  32 each  registered W-stage values.
- W_WRA  output  5  registered destination register.

## Operation
- Decode on M_instruc[31:26]: lw 100011, lb 100000, lbu 100100, lh 100001, lhu 100101, sw 101011, sh 101001, sb 101000. All other opcodes: no memory access.
- A = M_AluRe. Exception when access requested and: A ≥ 4*DM_WORDS; or lw/sw with A[1:0]≠0; or lh/lhu/sh with A[0]≠0. Loads give code 4, stores code 5. Byte accesses are never misaligned.
- Byte enables (store, no exception, IntReq=0, reset=0): sw 4'b1111; sh 4'b0011 << A[1:0]; sb 4'b0001 << A[1:0]. Otherwise 4'b0000.
- Store data lanes: sw M_WD; sh {2{M_WD[15:0]}}; sb {4{M_WD[7:0]}}. Only enabled lanes of word A[31:2] update at the clock edge.
- Load data, sampled from memory word A[31:2] at the edge, right-justified into W_DM: lw full word; lh/lhu selected halfword in [15:0], [31:16]=0; lb/lbu selected byte in [7:0], [31:8]=0. Extension is done in write-back, never here. Non-load: W_DM=0.
- W-register update each edge:
  - reset=1: all W outputs ← 0; every memory word ← 0.
  - IntReq=1: all W outputs ← 0 (nop bubble); no memory write.
  - M_Exc=1: W_instruc ← 0, W_WRA ← 0, W_DM ← 0; W_PC, W_AluRe ← M values; no memory write.
  - otherwise: W_instruc, W_PC, W_AluRe, W_WRA ← M values; W_DM ← load data.
- Priority: reset > IntReq > M_Exc > normal.

## Timing
- Reset value of every registered output: 0. Memory all-zero after one reset cycle.
- M_Exc, M_ExcCode, M_DMByteEn: combinational from M inputs and IntReq, same cycle.
- Load latency: one cycle; data appears on W_DM after the edge ending the load's M cycle.
- Store is visible to a load in M the following cycle (read reflects the write committed at the preceding edge). A single instruction never reads and writes in one cycle.
- No stall input; the M→W register advances every cycle.
- Reset asserted mid-sequence discards the M instruction and clears memory at that edge.

## Test plan
- Reset 1 cycle, then lw A=0x0 → W_DM=0x00000000, all W outputs 0 during reset.
- sw 0x12345678 to 0x10; next cycle lb A=0x11 → W_DM=0x00000056; lh A=0x12 → W_DM=0x00001234.
- sb 0xAB to 0x13 over stored 0x12345678 → M_DMByteEn=4'b1000; lw 0x10 → 0xAB345678.
- lw A=0x6 → M_Exc=1, M_ExcCode=4, W_instruc=0, W_WRA=0; sh A=0x3001 → code 5, memory unchanged.
- sw 0xFFFFFFFF to 0x20 with IntReq=1 → M_DMByteEn=0, W_PC=0, W_instruc=0; lw 0x20 → 0x00000000.
- Back-to-back sw then lw same address (0x2FFC, 0xCAFEBABE) → W_DM=0xCAFEBABE one cycle after lw in M.
